// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic result path.
package systolic_pkg;
  localparam int DIM   = 4;
  localparam int WIDTH = 8;
  localparam int ELEMS = DIM * DIM;
  localparam int IDX_W = $clog2(DIM);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/result_slot.sv
// One DIM x DIM matrix buffer: whole-matrix load, single-element read mux.
module result_slot #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic                                  clk_i,
  input  logic                                  load_i,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    d_i,
  input  logic [$clog2(DIM)-1:0]                row_i,
  input  logic [$clog2(DIM)-1:0]                col_i,
  output logic [WIDTH-1:0]                      data_o
);

  logic [DIM-1:0][DIM-1:0][WIDTH-1:0] mem_q;

  // Contents carry no reset; the streamer masks the output while idle.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    always_ff @(posedge clk_i) begin
      if (load_i) mem_q[r] <= d_i[r];
    end
  end

  assign data_o = mem_q[row_i][col_i];

endmodule

// File: rtl/result_streamer.sv
// Ping-pong buffer that serialises finished result matrices row-major
// onto a valid/ready element stream.
module result_streamer #(
  parameter int DIM   = systolic_pkg::DIM,
  parameter int WIDTH = systolic_pkg::WIDTH
) (
  input  logic                                  i_clk,
  input  logic                                  i_srst,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    i_c,
  input  logic                                  i_validResult,
  output logic [WIDTH-1:0]                      o_data,
  output logic [$clog2(DIM)-1:0]                o_row,
  output logic [$clog2(DIM)-1:0]                o_col,
  output logic                                  o_last,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic                                  o_busy,
  output logic                                  o_overflow,
  input  logic                                  i_clearOverflow
);
  import systolic_pkg::*;

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIM - 1);

  occ_e            state_q, state_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]   row_q, row_d;
  logic [IW-1:0]   col_q, col_d;
  logic            ovf_q, ovf_d;

  logic                  valid, at_last, xfer, last_xfer, capture, drop;
  logic [1:0]            load;
  logic [1:0][WIDTH-1:0] slot_data;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    result_slot #(.DIM(DIM), .WIDTH(WIDTH)) u_slot (
      .clk_i  (i_clk),
      .load_i (load[g]),
      .d_i    (i_c),
      .row_i  (row_q),
      .col_i  (col_q),
      .data_o (slot_data[g])
    );
  end

  // Outputs are forced idle while reset is held, even on its first cycle.
  assign valid     = (state_q != EMPTY) && !i_srst;
  assign at_last   = (row_q == IDX_MAX) && (col_q == IDX_MAX);
  assign xfer      = valid && i_ready;
  assign last_xfer = xfer && at_last;
  assign capture   = i_validResult && !i_srst && ((state_q != FULL) || last_xfer);
  assign drop      = i_validResult && !i_srst && (state_q == FULL) && !last_xfer;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    row_d    = row_q;
    col_d    = col_q;
    ovf_d    = ovf_q;
    load     = '0;

    if (xfer) begin
      if (at_last) begin
        row_d    = '0;
        col_d    = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else if (col_q == IDX_MAX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // In FULL with a last transfer the write slot is the one being freed.
    if (capture) begin
      load[wr_ptr_q] = 1'b1;
      wr_ptr_d       = ~wr_ptr_q;
    end

    case (state_q)
      EMPTY: if (capture) state_d = ONE;
      ONE: begin
        if (capture && !last_xfer)      state_d = FULL;
        else if (last_xfer && !capture) state_d = EMPTY;
      end
      FULL:  if (last_xfer && !capture) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    if (drop)                 ovf_d = 1'b1;
    else if (i_clearOverflow) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_valid    = valid;
  assign o_busy     = valid;
  assign o_data     = valid ? slot_data[rd_ptr_q] : '0;
  assign o_row      = valid ? row_q : '0;
  assign o_col      = valid ? col_q : '0;
  assign o_last     = valid && at_last;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer with DIM=4, WIDTH=8.
module tb_result_streamer;
  logic                  i_clk = 1'b0;
  logic                  i_srst;
  logic [3:0][3:0][7:0]  i_c;
  logic                  i_validResult;
  logic [7:0]            o_data;
  logic [1:0]            o_row, o_col;
  logic                  o_last, o_valid, i_ready, o_busy, o_overflow, i_clearOverflow;

  int vecs = 0;
  int errs = 0;

  result_streamer #(.DIM(4), .WIDTH(8)) dut (
    .i_clk(i_clk), .i_srst(i_srst), .i_c(i_c), .i_validResult(i_validResult),
    .o_data(o_data), .o_row(o_row), .o_col(o_col), .o_last(o_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
    .o_overflow(o_overflow), .i_clearOverflow(i_clearOverflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mat(input int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        i_c[r][c] = 8'(base + r * 4 + c);
  endtask

  task automatic beat(input string tag, input int base, input int k);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_data"},  32'(o_data),  32'((base + k) & 8'hFF));
    chk({tag, "_row"},   32'(o_row),   32'(k / 4));
    chk({tag, "_col"},   32'(o_col),   32'(k % 4));
    chk({tag, "_last"},  32'(o_last),  32'(k == 15));
  endtask

  task automatic idle(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_last"},  32'(o_last),  32'd0);
  endtask

  task automatic pulse(input int base);
    load_mat(base);
    i_validResult = 1'b1;
    tick();
    i_validResult = 1'b0;
  endtask

  initial begin
    int e;
    int n;
    logic [3:0] rdy_pat;
    i_srst = 1'b1; i_validResult = 1'b0; i_ready = 1'b0; i_clearOverflow = 1'b0;
    load_mat(8'hEE);
    rdy_pat = 4'b1001;

    // Reset state
    tick(); tick();
    idle("rst");
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_row", 32'(o_row), 32'd0);
    chk("rst_col", 32'(o_col), 32'd0);
    i_srst = 1'b0;
    tick();
    idle("pre1");

    // Single matrix, always ready
    i_ready = 1'b1;
    pulse(0);
    for (int k = 0; k < 16; k++) begin
      beat("single", 0, k);
      tick();
    end
    idle("single_end");

    // Back-pressure 1,0,0,1
    pulse(0);
    e = 0; n = 0;
    while (e < 16 && n < 100) begin
      i_ready = rdy_pat[n % 4];
      beat("bp", 0, e);
      if (i_ready) e++;
      n++;
      tick();
    end
    chk("bp_count", 32'(e), 32'd16);
    idle("bp_end");

    // Two pulses three cycles apart, no bubble
    i_ready = 1'b1;
    pulse(8'h10);
    for (int k = 0; k < 32; k++) begin
      if (k < 16) beat("pp_a", 8'h10, k);
      else        beat("pp_b", 8'h20, k - 16);
      if (k == 2) begin load_mat(8'h20); i_validResult = 1'b1; end
      else        i_validResult = 1'b0;
      tick();
    end
    idle("pp_end");

    // Overflow while FULL and stalled
    i_ready = 1'b0;
    pulse(8'h30);
    pulse(8'h40);
    chk("ovf_pre", 32'(o_overflow), 32'd0);
    pulse(8'h50);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk("ovf_busy", 32'(o_busy), 32'd1);
    i_clearOverflow = 1'b1;
    pulse(8'h58);
    chk("ovf_setwins", 32'(o_overflow), 32'd1);
    tick();
    i_clearOverflow = 1'b0;
    chk("ovf_clear", 32'(o_overflow), 32'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k < 16) beat("ovf_a", 8'h30, k);
      else        beat("ovf_b", 8'h40, k - 16);
      tick();
    end
    idle("ovf_end");

    // Capture coincident with last transfer in FULL
    i_ready = 1'b0;
    pulse(8'h60);
    pulse(8'h70);
    i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      beat("cl_a", 8'h60, k);
      if (k == 15) begin load_mat(8'h80); i_validResult = 1'b1; end
      tick();
    end
    i_validResult = 1'b0;
    chk("cl_ovf", 32'(o_overflow), 32'd0);
    for (int k = 0; k < 32; k++) begin
      if (k < 16) beat("cl_b", 8'h70, k);
      else        beat("cl_c", 8'h80, k - 16);
      tick();
    end
    idle("cl_end");

    // Reset mid-stream of a FULL buffer
    i_ready = 1'b0;
    pulse(8'h90);
    pulse(8'hA0);
    i_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      beat("sr_a", 8'h90, k);
      tick();
    end
    beat("sr_b7", 8'h90, 7);
    i_srst = 1'b1;
    load_mat(8'hC0);
    i_validResult = 1'b1;
    tick();
    i_validResult = 1'b0;
    idle("sr_during");
    i_srst = 1'b0;
    tick();
    idle("sr_after");
    pulse(8'hB0);
    for (int k = 0; k < 16; k++) begin
      beat("sr_new", 8'hB0, k);
      tick();
    end
    idle("sr_end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
